// File: rtl/readreg.sv
// Register-read stage between rename and issue: reads operands, merges same-cycle
// writeback, holds under stall. Optional macro READREG_WB_BYPASS_EN enables wb bypass/snoop.
module readreg #(
  parameter int READREG_WIDTH    = 2,
  parameter int WB_WIDTH         = 4,
  parameter int PHY_REG_ID_WIDTH = 6,
  parameter int REG_DATA_WIDTH   = 32,
  parameter int PAYLOAD_WIDTH    = 64
) (
  input  logic                                                      clk,
  input  logic                                                      rst,
  input  logic [READREG_WIDTH-1:0]                                  rename_readreg_valid,
  input  logic [READREG_WIDTH-1:0][1:0][PHY_REG_ID_WIDTH-1:0]       rename_readreg_src_id,
  input  logic [READREG_WIDTH-1:0][1:0]                             rename_readreg_src_need,
  input  logic [READREG_WIDTH-1:0][PAYLOAD_WIDTH-1:0]               rename_readreg_payload,
  output logic                                                      readreg_rename_stall,
  output logic [READREG_WIDTH-1:0][1:0][PHY_REG_ID_WIDTH-1:0]       readreg_phyf_id,
  input  logic [READREG_WIDTH-1:0][1:0][REG_DATA_WIDTH-1:0]         phyf_readreg_data,
  input  logic [READREG_WIDTH-1:0][1:0]                             phyf_readreg_data_valid,
  input  logic [WB_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0]                 wb_phyf_id,
  input  logic [WB_WIDTH-1:0][REG_DATA_WIDTH-1:0]                   wb_phyf_data,
  input  logic [WB_WIDTH-1:0]                                       wb_phyf_we,
  output logic [READREG_WIDTH-1:0]                                  readreg_issue_valid,
  output logic [READREG_WIDTH-1:0][1:0][REG_DATA_WIDTH-1:0]         readreg_issue_src_data,
  output logic [READREG_WIDTH-1:0][1:0]                             readreg_issue_src_ready,
  output logic [READREG_WIDTH-1:0][PAYLOAD_WIDTH-1:0]               readreg_issue_payload,
  input  logic                                                      issue_readreg_stall,
  input  logic                                                      commit_readreg_flush
);

  genvar gi, gk;

  assign readreg_rename_stall = issue_readreg_stall;
  assign readreg_phyf_id      = rename_readreg_src_id;

`ifdef READREG_WB_BYPASS_EN
  // Returns {hit, data}; the lowest-numbered matching port wins.
  function automatic logic [REG_DATA_WIDTH:0] wb_match(
    input logic [PHY_REG_ID_WIDTH-1:0]                 id,
    input logic [WB_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0]   wid,
    input logic [WB_WIDTH-1:0][REG_DATA_WIDTH-1:0]     wdata,
    input logic [WB_WIDTH-1:0]                         we
  );
    logic [REG_DATA_WIDTH:0] r;
    r = '0;
    for (int w = WB_WIDTH - 1; w >= 0; w--) begin
      if (we[w] && (wid[w] == id)) r = {1'b1, wdata[w]};
    end
    return r;
  endfunction
`else
  logic unused_wb;
  assign unused_wb = ^{wb_phyf_id, wb_phyf_data, wb_phyf_we};
`endif

  for (gi = 0; gi < READREG_WIDTH; gi++) begin : g_slot
    logic                     valid_reg, valid_next;
    logic [PAYLOAD_WIDTH-1:0] payload_reg, payload_next;

    always_comb begin
      valid_next   = valid_reg;
      payload_next = payload_reg;
      if (commit_readreg_flush) begin
        valid_next   = 1'b0;
        payload_next = '0;
      end else if (!issue_readreg_stall) begin
        valid_next   = rename_readreg_valid[gi];
        payload_next = rename_readreg_payload[gi];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_reg   <= 1'b0;
        payload_reg <= '0;
      end else begin
        valid_reg   <= valid_next;
        payload_reg <= payload_next;
      end
    end

    assign readreg_issue_valid[gi]   = valid_reg;
    assign readreg_issue_payload[gi] = payload_reg;

    for (gk = 0; gk < 2; gk++) begin : g_src
      logic                      ready_reg, ready_next;
      logic [REG_DATA_WIDTH-1:0] data_reg, data_next;
`ifdef READREG_WB_BYPASS_EN
      logic [PHY_REG_ID_WIDTH-1:0] id_reg;
      logic [REG_DATA_WIDTH:0]     cap_hit, snoop_hit;

      assign cap_hit   = wb_match(rename_readreg_src_id[gi][gk], wb_phyf_id, wb_phyf_data, wb_phyf_we);
      assign snoop_hit = wb_match(id_reg, wb_phyf_id, wb_phyf_data, wb_phyf_we);

      // Held ids let a stalled entry pick up its operand when it is written back.
      always_ff @(posedge clk) begin
        if (rst) id_reg <= '0;
        else if (!commit_readreg_flush && !issue_readreg_stall) id_reg <= rename_readreg_src_id[gi][gk];
      end
`endif

      always_comb begin
        ready_next = ready_reg;
        data_next  = data_reg;
        if (commit_readreg_flush) begin
          ready_next = 1'b0;
          data_next  = '0;
        end else if (!issue_readreg_stall) begin
          if (!rename_readreg_src_need[gi][gk]) begin
            ready_next = 1'b1;
            data_next  = '0;
`ifdef READREG_WB_BYPASS_EN
          end else if (cap_hit[REG_DATA_WIDTH]) begin
            ready_next = 1'b1;
            data_next  = cap_hit[REG_DATA_WIDTH-1:0];
`endif
          end else begin
            ready_next = phyf_readreg_data_valid[gi][gk];
            data_next  = phyf_readreg_data[gi][gk];
          end
        end
`ifdef READREG_WB_BYPASS_EN
        else if (valid_reg && !ready_reg && snoop_hit[REG_DATA_WIDTH]) begin
          ready_next = 1'b1;
          data_next  = snoop_hit[REG_DATA_WIDTH-1:0];
        end
`endif
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          ready_reg <= 1'b0;
          data_reg  <= '0;
        end else begin
          ready_reg <= ready_next;
          data_reg  <= data_next;
        end
      end

      assign readreg_issue_src_ready[gi][gk] = ready_reg;
      assign readreg_issue_src_data[gi][gk]  = data_reg;
    end
  end

endmodule
